// File: rtl/regfile_wport_arbiter_pkg.sv
// rtl/regfile_wport_arbiter_pkg.sv - shared types for the register-file write-port arbiter
package regfile_wport_arbiter_pkg;

   typedef logic [63:0] u64;
   typedef logic [4:0]  creg_addr_t;
   typedef u64          word_t;

   localparam int NSRC_WB = 2;

   // One buffered writeback request; valid doubles as the skid buffer's full flag.
   typedef struct packed {
      logic       valid;
      creg_addr_t addr;
      word_t      data;
   } wb_req_t;

   // One-hot grant vector for a source index.
   function automatic logic [1:0] onehot_src(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/regfile_wport_skid.sv
// rtl/regfile_wport_skid.sv - one-entry writeback skid buffer with grant-driven drain
module regfile_wport_skid
   import regfile_wport_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wb_valid,
   input  creg_addr_t i_wb_addr,
   input  word_t      i_wb_data,
   input  logic       i_grant,
   output logic       o_wb_ready,
   output logic       o_full,
   output creg_addr_t o_addr,
   output word_t      o_data
);

   wb_req_t r_entry;
   logic    w_accept;

   // Ready depends only on buffer state and grant, so it never loops back through wb_valid.
   assign o_wb_ready = !r_entry.valid || i_grant;
   assign w_accept   = i_wb_valid && o_wb_ready;

   assign o_full = r_entry.valid;
   assign o_addr = r_entry.addr;
   assign o_data = r_entry.data;

   // Drain on grant and refill on accept in the same cycle, giving 1 write/cycle per source.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_entry <= '0;
      end else begin
         r_entry.valid <= (r_entry.valid && !i_grant) || w_accept;
         if (w_accept) begin
            r_entry.addr <= i_wb_addr;
            r_entry.data <= i_wb_data;
         end
      end
   end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - two-source register-file write-port arbiter (optional forwarding: REGFILE_WPORT_FWD_EN)
module regfile_wport_arbiter
   import regfile_wport_arbiter_pkg::*;
#(
   parameter int NSRC = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NSRC-1:0]       i_wb_valid,
   output logic [NSRC-1:0]       o_wb_ready,
   input  creg_addr_t [NSRC-1:0] i_wb_addr,
   input  word_t [NSRC-1:0]      i_wb_data,
   output logic                  o_rf_wen,
   output creg_addr_t            o_rf_wa,
   output word_t                 o_rf_wd,
   output logic [NSRC-1:0]       o_pend
`ifdef REGFILE_WPORT_FWD_EN
   ,
   input  creg_addr_t [NSRC-1:0] i_fwd_ra,
   output logic [NSRC-1:0]       o_fwd_hit,
   output word_t [NSRC-1:0]      o_fwd_data
`endif
);

   if (NSRC != NSRC_WB) begin : g_bad_nsrc
      $error("regfile_wport_arbiter: NSRC must be 2");
   end

   logic [NSRC-1:0]       w_full;
   logic [NSRC-1:0]       w_grant;
   creg_addr_t [NSRC-1:0] w_addr;
   word_t [NSRC-1:0]      w_data;
   logic                  w_both;
   logic                  w_gsel;

   logic       r_rr_ptr;
   logic       r_rf_wen;
   creg_addr_t r_rf_wa;
   word_t      r_rf_wd;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      regfile_wport_skid u_skid (
         .i_clk      (i_clk),
         .i_reset    (i_reset),
         .i_wb_valid (i_wb_valid[gi]),
         .i_wb_addr  (i_wb_addr[gi]),
         .i_wb_data  (i_wb_data[gi]),
         .i_grant    (w_grant[gi]),
         .o_wb_ready (o_wb_ready[gi]),
         .o_full     (w_full[gi]),
         .o_addr     (w_addr[gi]),
         .o_data     (w_data[gi])
      );
   end

   assign w_both = w_full[0] && w_full[1];
   assign w_gsel = w_grant[1];

   // Grant from buffer state only; a same-register clash lets source 1 (the older op) go first.
   always_comb begin
      w_grant = '0;
      if (w_both) begin
         if (w_addr[0] == w_addr[1]) begin
            w_grant = 2'b10;
         end else begin
            w_grant = onehot_src(r_rr_ptr);
         end
      end else begin
         w_grant = w_full;
      end
   end

   // Registered write port; x0 drains through but never raises wen, and rr flips only on contended grants.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rr_ptr <= 1'b0;
         r_rf_wen <= 1'b0;
         r_rf_wa  <= '0;
         r_rf_wd  <= '0;
      end else begin
         if (|w_grant) begin
            r_rf_wen <= (w_addr[w_gsel] != '0);
            r_rf_wa  <= w_addr[w_gsel];
            r_rf_wd  <= w_data[w_gsel];
         end else begin
            r_rf_wen <= 1'b0;
         end
         if (w_both) begin
            r_rr_ptr <= ~w_gsel;
         end
      end
   end

   assign o_rf_wen = r_rf_wen;
   assign o_rf_wa  = r_rf_wa;
   assign o_rf_wd  = r_rf_wd;
   assign o_pend   = w_full;

`ifdef REGFILE_WPORT_FWD_EN
   // Bypass the value being written this cycle, which the register file's read ports do not yet show.
   always_comb begin
      o_fwd_hit  = '0;
      o_fwd_data = '0;
      for (int j = 0; j < NSRC; j++) begin
         if (r_rf_wen && (r_rf_wa == i_fwd_ra[j]) && (i_fwd_ra[j] != '0)) begin
            o_fwd_hit[j]  = 1'b1;
            o_fwd_data[j] = r_rf_wd;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - directed self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;

   logic              clk;
   logic              reset;
   logic [1:0]        wb_valid;
   logic [1:0]        wb_ready;
   logic [1:0][4:0]   wb_addr;
   logic [1:0][63:0]  wb_data;
   logic              rf_wen;
   logic [4:0]        rf_wa;
   logic [63:0]       rf_wd;
   logic [1:0]        pend;
`ifdef REGFILE_WPORT_FWD_EN
   logic [1:0][4:0]   fwd_ra;
   logic [1:0]        fwd_hit;
   logic [1:0][63:0]  fwd_data;
`endif

   logic [63:0] regs [32];
   int n_cmp;
   int n_err;

   regfile_wport_arbiter #(.NSRC(2)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_wb_valid (wb_valid),
      .o_wb_ready (wb_ready),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .o_rf_wen   (rf_wen),
      .o_rf_wa    (rf_wa),
      .o_rf_wd    (rf_wd),
      .o_pend     (pend)
`ifdef REGFILE_WPORT_FWD_EN
      ,
      .i_fwd_ra   (fwd_ra),
      .o_fwd_hit  (fwd_hit),
      .o_fwd_data (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model fed by the write port
   always @(posedge clk) begin
      if (rf_wen) regs[rf_wa] <= rf_wd;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0]  acc;
      logic [63:0] exp_wd;
      logic [4:0]  exp_wa;
      int c0, c1, nw, first, last;

      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      reset = 1'b1;
      wb_valid = '0;
      wb_addr = '0;
      wb_data = '0;
`ifdef REGFILE_WPORT_FWD_EN
      fwd_ra = '0;
`endif
      tick();
      tick();
      check("rst_wen", rf_wen, 0);
      check("rst_wa", rf_wa, 0);
      check("rst_wd", rf_wd, 0);
      check("rst_pend", pend, 0);
      check("rst_ready", wb_ready, 2'b11);
      reset = 1'b0;

      // Lone source 0 write x5
      wb_valid = 2'b01;
      wb_addr[0] = 5'd5;
      wb_data[0] = 64'h1111;
      check("t1_ready_pre", wb_ready[0], 1);
      tick();
      wb_valid = '0;
      check("t1_pend", pend, 2'b01);
      check("t1_wen0", rf_wen, 0);
      check("t1_ready_full", wb_ready[0], 1);
      tick();
      check("t1_wen", rf_wen, 1);
      check("t1_wa", rf_wa, 5);
      check("t1_wd", rf_wd, 64'h1111);
      check("t1_ready_post", wb_ready[0], 1);
      tick();
      check("t1_wen_off", rf_wen, 0);
      check("t1_wa_hold", rf_wa, 5);
      check("t1_wd_hold", rf_wd, 64'h1111);
      check("t1_x5", regs[5], 64'h1111);

      // Both sources streaming, different addresses: alternate starting with source 0
      c0 = 0; c1 = 0; nw = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         wb_valid[0] = (c0 < 4);
         wb_valid[1] = (c1 < 4);
         wb_addr[0]  = 5'd3;
         wb_addr[1]  = 5'd7;
         wb_data[0]  = 64'h100 + 64'(c0);
         wb_data[1]  = 64'h200 + 64'(c1);
         acc = wb_valid & wb_ready;
         tick();
         if (acc[0]) c0++;
         if (acc[1]) c1++;
         if (rf_wen) begin
            exp_wa = nw[0] ? 5'd7 : 5'd3;
            exp_wd = (nw[0] ? 64'h200 : 64'h100) + 64'(nw / 2);
            check("t2_wa", rf_wa, exp_wa);
            check("t2_wd", rf_wd, exp_wd);
            if (first < 0) first = cyc;
            last = cyc;
            nw++;
         end
      end
      wb_valid = '0;
      check("t2_nwrites", nw, 8);
      check("t2_first_cyc", first, 1);
      check("t2_back_to_back", last - first, 7);
      check("t2_x3", regs[3], 64'h103);
      check("t2_x7", regs[7], 64'h203);

      // Reset with both buffers full drops everything
      wb_valid = 2'b11;
      wb_addr[0] = 5'd10;
      wb_addr[1] = 5'd11;
      wb_data[0] = 64'h55;
      wb_data[1] = 64'h66;
      tick();
      wb_valid = '0;
      check("t5_pend_full", pend, 2'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_wen", rf_wen, 0);
      check("t5_pend", pend, 0);
      check("t5_wa", rf_wa, 0);
      check("t5_wd", rf_wd, 0);
      tick();
      check("t5_wen_a", rf_wen, 0);
      tick();
      check("t5_wen_b", rf_wen, 0);
      check("t5_x10", regs[10], 0);
      check("t5_x11", regs[11], 0);

      // Same-address conflict: source 1 lands first, source 0 last
      wb_valid = 2'b11;
      wb_addr[0] = 5'd9;
      wb_addr[1] = 5'd9;
      wb_data[0] = 64'hA;
      wb_data[1] = 64'hB;
      tick();
      wb_valid = '0;
      check("t3_pend", pend, 2'b11);
      tick();
      check("t3_wen1", rf_wen, 1);
      check("t3_wa1", rf_wa, 9);
      check("t3_wd1", rf_wd, 64'hB);
      check("t3_pend1", pend, 2'b01);
      tick();
      check("t3_wen2", rf_wen, 1);
      check("t3_wd2", rf_wd, 64'hA);
      tick();
      check("t3_wen_off", rf_wen, 0);
      check("t3_x9", regs[9], 64'hA);

      // Round-robin pointer back at source 0 after the conflict
      wb_valid = 2'b11;
      wb_addr[0] = 5'd10;
      wb_addr[1] = 5'd11;
      wb_data[0] = 64'h77;
      wb_data[1] = 64'h88;
      tick();
      wb_valid = '0;
      tick();
      check("rr_wa1", rf_wa, 10);
      check("rr_wd1", rf_wd, 64'h77);
      tick();
      check("rr_wa2", rf_wa, 11);
      check("rr_wd2", rf_wd, 64'h88);
      tick();
      check("rr_x11", regs[11], 64'h88);

      // Write to x0 drains without asserting wen
      wb_valid = 2'b10;
      wb_addr[1] = 5'd0;
      wb_data[1] = 64'hDEAD;
      check("t4_ready", wb_ready[1], 1);
      tick();
      wb_valid = '0;
      check("t4_pend", pend, 2'b10);
      check("t4_wen_a", rf_wen, 0);
      tick();
      check("t4_wen_b", rf_wen, 0);
      check("t4_wa", rf_wa, 0);
      check("t4_wd", rf_wd, 64'hDEAD);
      check("t4_pend_clr", pend, 0);
      tick();
      check("t4_wen_c", rf_wen, 0);
      check("t4_x0", regs[0], 0);

`ifdef REGFILE_WPORT_FWD_EN
      // Forwarding only during the cycle the write is on the port
      fwd_ra[0] = 5'd12;
      fwd_ra[1] = 5'd13;
      wb_valid = 2'b01;
      wb_addr[0] = 5'd12;
      wb_data[0] = 64'h42;
      tick();
      wb_valid = '0;
      check("fwd_hit_pre", fwd_hit, 0);
      tick();
      check("fwd_hit", fwd_hit, 2'b01);
      check("fwd_data0", fwd_data[0], 64'h42);
      check("fwd_data1", fwd_data[1], 0);
      tick();
      check("fwd_hit_post", fwd_hit, 0);
      check("fwd_data_post", fwd_data[0], 0);
      check("fwd_x12", regs[12], 64'h42);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port (wen/wa/wd) between two writeback requesters.
  - Source 0: in-order pipeline commit.
  - Source 1: multi-cycle unit (mul/div, late load).
- Each source has a 1-entry skid buffer. Arbitration is round-robin, except that a same-register conflict resolves in a fixed order.
- The write-port outputs are registered and connect directly to the register file's wen/wa/wd.

Parameters:
- NSRC, 2, number of requesters; fixed at 2. Any other value is an elaboration error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wb_valid  in  [1:0]  source i presents a write
- wb_ready  out  [1:0]  source i write accepted this cycle when valid&ready
- wb_addr  in  2 x creg_addr_t (5b)  destination register per source
- wb_data  in  2 x word_t (64b)  write data per source
- rf_wen  out  1  register-file write enable
- rf_wa  out  creg_addr_t  register-file write address
- rf_wd  out  word_t  register-file write data
- pend  out  [1:0]  skid buffer i occupied (debug/stall hint)

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high; all state updates on posedge clk.
  - Reset clears both buffers, sets rr_ptr=0, rf_wen=0, rf_wa=0, rf_wd=0.
  - Reset asserted mid-operation drops all buffered writes; nothing is written.
- Per-source buffer: full_i, addr_i, data_i.
- Grant, combinational from buffer state only (never from wb_valid):
  - Only one buffer full: it wins.
  - Both full and addr_0==addr_1: source 1 wins. The long-latency op is older, so source 0's value must land last.
  - Both full, different addresses: winner = rr_ptr. On each grant taken while both were full, rr_ptr <= ~winner.
- Ready: wb_ready[i] = !full_i || grant_i. No combinational path from wb_valid to wb_ready.
- Buffer update: full_i <= (full_i && !grant_i) || (wb_valid[i] && wb_ready[i]). On accept, addr_i/data_i load the inputs.
- Output register:
  - Each cycle with a grant: rf_wen <= (addr_g != 0), rf_wa <= addr_g, rf_wd <= data_g.
  - No grant: rf_wen <= 0; rf_wa/rf_wd hold.
  - Writes to x0 are accepted and drained but never assert rf_wen.
- Latency:
  - Source accepted at edge k, granted in cycle k..k+1 with no competitor: rf_wen high in cycle k+1..k+2.
  - Register file commits at edge k+2.
- Throughput:
  - A lone source sustains 1 write/cycle.
  - Both sources active: combined 1 write/cycle, alternating except under same-address conflict.
- Ordering:
  - Writes from the same source reach the port in acceptance order.
  - Same-address conflicts always commit source 1 then source 0.
- pend = {full_1, full_0}.

Optional Feature:
- Macro: REGFILE_WPORT_FWD_EN.
- Defined, adds ports:
  - fwd_ra  in  2 x creg_addr_t
  - fwd_hit  out  [1:0]
  - fwd_data  out  2 x word_t
- fwd_hit[j] = rf_wen && rf_wa==fwd_ra[j] && fwd_ra[j]!=0. When hit, fwd_data[j] = rf_wd; otherwise 0.
- This covers the cycle in which the write is presented but the register file's read ports still return the old value.
- Not defined: the ports are absent and there is no extra logic.

Decomposition:
- pipes package gains:
  - wb_req_t struct {logic valid; creg_addr_t addr; word_t data;}
  - constant NSRC_WB = 2
- creg_addr_t, word_t, u64 come from common.
- One natural sub-module: regfile_wport_skid (1-entry buffer with full flag, grant input, ready output), instantiated per source.

Test Plan:
- Reset, then source 0 alone writes x5=0x1111 at edge 1 -> rf_wen=1, rf_wa=5, rf_wd=0x1111 in cycle 2; register-file x5==0x1111 after edge 3; wb_ready[0] stays 1.
- Both valid every cycle, addr 3 vs 7, 4 writes each -> rf_wa sequence alternates starting with source 0; 8 writes in 8 consecutive cycles after the first; no write lost.
- Both buffers full with addr 9, data0=0xA, data1=0xB -> rf_wd=0xB then 0xA on consecutive cycles; final x9==0xA.
- Source 1 writes x0=0xDEAD -> wb_ready handshake completes; rf_wen stays 0; x0 reads 0.
- Both buffers full, reset asserted one cycle -> next cycle rf_wen=0, pend=0, rr_ptr=0; no buffered data reaches the register file.
- REGFILE_WPORT_FWD_EN defined, write x12=0x42, fwd_ra[0]=12 -> fwd_hit[0]=1, fwd_data[0]=0x42 only in the cycle rf_wen=1; next cycle fwd_hit=0 and the register-file read returns 0x42.
